// File: rtl/lvds_tx_scheduler_pkg.sv
// Shared definitions for the LVDS transmit scheduler: FSM encoding,
// default header marker and the header word builder.
package lvds_tx_scheduler_pkg;

  // What data_o currently holds.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // IDLE_WORD (no packet)
    S_HDR  = 2'd1,  // packet header
    S_PLD  = 2'd2   // payload word number cnt
  } state_t;

  localparam logic [7:0] HDR_MARK_DEFAULT = 8'hA5;

  // Widest word the header builder can produce (64 bytes).
  localparam int HDR_MAX_W = 512;

  // Header layout: marker in the top byte, source index in the low byte,
  // zeros in between. The caller truncates the result to its word width.
  function automatic logic [HDR_MAX_W-1:0] make_header(input logic [7:0] mark,
                                                       input logic [7:0] src,
                                                       input int         word_w);
    logic [HDR_MAX_W-1:0] hdr;
    hdr                 = '0;
    hdr[7:0]            = src;
    hdr[word_w-8 +: 8]  = mark;
    return hdr;
  endfunction

endpackage

// File: rtl/lvds_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one position after
// the previous winner and wraps modulo N, so every requester gets a turn.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int GW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last,
  output logic [N-1:0]  grant_oh,
  output logic          valid
);

  logic [GW-1:0] idx;

  // Walk requesters in priority order last+1 .. last+N, first hit wins.
  always_comb begin
    grant_oh = '0;
    valid    = 1'b0;
    idx      = '0;
    for (int k = 1; k <= N; k++) begin
      idx = GW'((int'(last) + k) % N);
      if (!valid && req[idx]) begin
        grant_oh[idx] = 1'b1;
        valid         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lvds_tx_scheduler.sv
// LVDS transmit scheduler: multiplexes packets from several requesters onto
// the word stream feeding an 8b10b serializer. Each packet is a header word
// followed by PKT_WORDS payload words from one source; fill words are
// inserted when the granted source runs dry, but a packet is never cut.
//
// Handshake: src_valid[i] means source i has a payload word on
// src_data[i]. src_ready[i] is a combinational pop strobe, high for exactly
// the cycle in which that word is copied into data_o; the source must
// advance to its next word after a cycle with src_valid & src_ready both
// high. On the serializer side, data_o is consumed on every rising edge
// where data_read_i is high, and data_o only changes on such edges.
module lvds_tx_scheduler
  import lvds_tx_scheduler_pkg::*;
#(
  parameter int                     NUM_BYTES = 2,
  parameter int                     NUM_SRC   = 4,
  parameter int                     PKT_WORDS = 4,
  parameter logic [8*NUM_BYTES-1:0] IDLE_WORD = '0,
  parameter logic [7:0]             HDR_MARK  = HDR_MARK_DEFAULT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_SRC-1:0]             src_valid,
  input  logic [NUM_SRC*8*NUM_BYTES-1:0] src_data,
  output logic [NUM_SRC-1:0]             src_ready,
  output logic [8*NUM_BYTES-1:0]         data_o,
  input  logic                           data_read_i,
  output logic                           busy_o,
  output logic                           underrun_o,
  output state_t                         dbg_state,
  output logic [7:0]                     dbg_cnt
);

  localparam int WORD_W = 8 * NUM_BYTES;
  localparam int GW     = $clog2(NUM_SRC);

  state_t              state, state_n;
  logic [7:0]          cnt, cnt_n;
  logic [GW-1:0]       grant, grant_n;     // also the round-robin pointer
  logic [WORD_W-1:0]   data_n;
  logic                under_n;
  logic [NUM_SRC-1:0]  ready_raw;

  logic [NUM_SRC-1:0]  arb_oh;
  logic                arb_valid;
  logic [GW-1:0]       arb_idx;
  logic [WORD_W-1:0]   hdr_word;
  logic [WORD_W-1:0]   src_word;
  logic                src_v;
  logic                at_last;

  rr_arbiter #(
    .N  (NUM_SRC),
    .GW (GW)
  ) u_arb (
    .req      (src_valid),
    .last     (grant),
    .grant_oh (arb_oh),
    .valid    (arb_valid)
  );

  // One-hot winner to index, and the header word that announces it.
  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (arb_oh[i]) arb_idx = GW'(i);
    end
    hdr_word = WORD_W'(make_header(HDR_MARK, 8'(arb_idx), WORD_W));
  end

  assign src_word = src_data[int'(grant)*WORD_W +: WORD_W];
  assign src_v    = src_valid[grant];
  assign at_last  = (state == S_PLD) && (cnt == 8'(PKT_WORDS - 1));

  // Next state, next word and pop strobe; nothing moves without a read strobe.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    grant_n   = grant;
    data_n    = data_o;
    under_n   = underrun_o;
    ready_raw = '0;
    if (data_read_i) begin
      if (state == S_IDLE || at_last) begin
        // Packet boundary: pick the next source or go idle.
        if (arb_valid) begin
          data_n  = hdr_word;
          grant_n = arb_idx;
          state_n = S_HDR;
        end else begin
          data_n  = IDLE_WORD;
          state_n = S_IDLE;
        end
      end else if (state == S_HDR || state == S_PLD) begin
        // Inside a packet: fetch the next payload word or insert a fill word.
        if (src_v) begin
          data_n           = src_word;
          ready_raw[grant] = 1'b1;
          state_n          = S_PLD;
          cnt_n            = (state == S_HDR) ? 8'd0 : cnt + 8'd1;
        end else begin
          data_n  = IDLE_WORD;
          under_n = 1'b1;
        end
      end else begin
        data_n  = IDLE_WORD;
        state_n = S_IDLE;
      end
    end
  end

  // Pops are suppressed while reset is held.
  assign src_ready = ready_raw & {NUM_SRC{reset}};

  // State, output word and sticky flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= 8'd0;
      grant      <= GW'(NUM_SRC - 1);
      data_o     <= IDLE_WORD;
      underrun_o <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      grant      <= grant_n;
      data_o     <= data_n;
      underrun_o <= under_n;
    end
  end

  assign busy_o    = (state != S_IDLE);
  assign dbg_state = state;
  assign dbg_cnt   = cnt;

endmodule

// File: tb/tb_lvds_tx_scheduler.sv
// Self-checking bench for lvds_tx_scheduler (2-byte words, 4 sources,
// 4-word packets): vector table, hand-written corner sequences and a
// randomized run against a packet-level reference model.
module tb_lvds_tx_scheduler;
  import lvds_tx_scheduler_pkg::*;

  localparam int NB = 2;
  localparam int NS = 4;
  localparam int PW = 4;
  localparam int W  = 8 * NB;

  logic          clk = 1'b0;
  logic          reset;
  logic [NS-1:0] src_valid;
  logic [63:0]   src_data;
  logic [NS-1:0] src_ready;
  logic [W-1:0]  data_o;
  logic          data_read_i;
  logic          busy_o;
  logic          underrun_o;
  state_t        dbg_state;
  logic [7:0]    dbg_cnt;

  int checks   = 0;
  int failures = 0;

  // Clock
  always #5 clk = ~clk;

  lvds_tx_scheduler #(
    .NUM_BYTES (NB),
    .NUM_SRC   (NS),
    .PKT_WORDS (PW),
    .IDLE_WORD (16'h0000),
    .HDR_MARK  (8'hA5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .src_valid   (src_valid),
    .src_data    (src_data),
    .src_ready   (src_ready),
    .data_o      (data_o),
    .data_read_i (data_read_i),
    .busy_o      (busy_o),
    .underrun_o  (underrun_o),
    .dbg_state   (dbg_state),
    .dbg_cnt     (dbg_cnt)
  );

  // ---------------------------------------------------------------- helpers
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mk(input int s, input logic [15:0] w);
    return 64'(w) << (16 * s);
  endfunction

  // Drive one cycle. Called at posedge+1; samples the combinational pop
  // strobe at the falling edge and returns at the next posedge+1.
  task automatic tick(input logic [3:0] v, input logic [63:0] d, input logic rd,
                      output logic [3:0] rdy);
    src_valid   = v;
    src_data    = d;
    data_read_i = rd;
    @(negedge clk);
    rdy = src_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset       = 1'b0;
    src_valid   = 4'b1111;
    src_data    = '0;
    data_read_i = 1'b1;
    #1;
    chk("rst_data",     64'(data_o), 64'h0);
    chk("rst_busy",     64'(busy_o), 64'h0);
    chk("rst_underrun", 64'(underrun_o), 64'h0);
    chk("rst_ready",    64'(src_ready), 64'h0);
    src_valid   = '0;
    data_read_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ----------------------------------------------------------- vector table
  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic [63:0] d;
    logic        rd;
    logic [15:0] e_data;
    logic [3:0]  e_rdy;
    logic        e_busy;
    logic        e_under;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [3:0] v, input logic [63:0] d,
                     input logic rd, input logic [15:0] ed, input logic [3:0] er,
                     input logic eb, input logic eu);
    vec_t r;
    r.rst = rst; r.v = v; r.d = d; r.rd = rd;
    r.e_data = ed; r.e_rdy = er; r.e_busy = eb; r.e_under = eu;
    tbl.push_back(r);
  endtask

  // ------------------------------------------------------- reference model
  // Packet-level view: a packet is "owner + payload words still owed".
  int          m_src;
  int          m_left;
  int          m_last;
  logic [15:0] m_data;
  logic        m_under;

  task automatic model_reset();
    m_src = -1; m_left = 0; m_last = NS - 1; m_data = 16'h0; m_under = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] v, input logic [63:0] d, input logic rd,
                            output logic [3:0] e_rdy);
    int g;
    e_rdy = 4'b0;
    if (!rd) return;
    if (m_src >= 0 && m_left > 0) begin
      if (v[m_src]) begin
        m_data = d[m_src*16 +: 16];
        e_rdy  = 4'(1 << m_src);
        m_left--;
      end else begin
        m_data  = 16'h0;
        m_under = 1'b1;
      end
    end else begin
      g = -1;
      for (int k = 1; k <= NS; k++) begin
        if (g < 0 && v[(m_last + k) % NS]) g = (m_last + k) % NS;
      end
      if (g >= 0) begin
        m_data = 16'hA500 | 16'(g);
        m_src  = g;
        m_left = PW;
        m_last = g;
      end else begin
        m_data = 16'h0;
        m_src  = -1;
      end
    end
  endtask

  // ------------------------------------------------------------------ test
  initial begin
    logic [3:0]  rdy;
    logic [3:0]  e_rdy;
    logic [3:0]  rv;
    logic [63:0] rdat;
    logic        rrd;
    int          pops[NS];
    int          s;

    // Idle: sparse reads with no requesters.
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      tick(4'b0, 64'h0, (i % 10) == 9, rdy);
      chk("idle_ready", 64'(rdy), 64'h0);
      chk("idle_data",  64'(data_o), 64'h0);
      chk("idle_busy",  64'(busy_o), 64'h0);
    end

    // Single source packet with one hold cycle.
    add(1, 4'b0100, mk(2, 16'h1111), 1, 16'hA502, 4'b0000, 1, 0);
    add(0, 4'b0100, mk(2, 16'h1111), 1, 16'h1111, 4'b0100, 1, 0);
    add(0, 4'b0100, mk(2, 16'h2222), 1, 16'h2222, 4'b0100, 1, 0);
    add(0, 4'b0100, mk(2, 16'h3333), 0, 16'h2222, 4'b0000, 1, 0);
    add(0, 4'b0100, mk(2, 16'h3333), 1, 16'h3333, 4'b0100, 1, 0);
    add(0, 4'b0100, mk(2, 16'h4444), 1, 16'h4444, 4'b0100, 1, 0);
    add(0, 4'b0000, 64'h0,           1, 16'h0000, 4'b0000, 0, 0);
    add(0, 4'b0000, 64'h0,           1, 16'h0000, 4'b0000, 0, 0);
    // Underrun on source 1 after its second word; source 0 waits its turn.
    add(1, 4'b0010, mk(1, 16'hAAA0), 1, 16'hA501, 4'b0000, 1, 0);
    add(0, 4'b0010, mk(1, 16'hAAA0), 1, 16'hAAA0, 4'b0010, 1, 0);
    add(0, 4'b0010, mk(1, 16'hAAA1), 1, 16'hAAA1, 4'b0010, 1, 0);
    add(0, 4'b0001, mk(0, 16'h5555) | mk(1, 16'hAAA2), 1, 16'h0000, 4'b0000, 1, 1);
    add(0, 4'b0001, mk(0, 16'h5555) | mk(1, 16'hAAA2), 1, 16'h0000, 4'b0000, 1, 1);
    add(0, 4'b0001, mk(0, 16'h5555) | mk(1, 16'hAAA2), 1, 16'h0000, 4'b0000, 1, 1);
    add(0, 4'b0010, mk(1, 16'hAAA2), 1, 16'hAAA2, 4'b0010, 1, 1);
    add(0, 4'b0010, mk(1, 16'hAAA3), 1, 16'hAAA3, 4'b0010, 1, 1);
    add(0, 4'b0000, 64'h0,           1, 16'h0000, 4'b0000, 0, 1);
    add(0, 4'b0001, mk(0, 16'h5555), 1, 16'hA500, 4'b0000, 1, 1);

    foreach (tbl[i]) begin
      if (tbl[i].rst) apply_reset();
      tick(tbl[i].v, tbl[i].d, tbl[i].rd, rdy);
      chk("tbl_ready",    64'(rdy),        64'(tbl[i].e_rdy));
      chk("tbl_data",     64'(data_o),     64'(tbl[i].e_data));
      chk("tbl_busy",     64'(busy_o),     64'(tbl[i].e_busy));
      chk("tbl_underrun", 64'(underrun_o), 64'(tbl[i].e_under));
    end

    // Fairness: every source always valid, five packets in rotation.
    apply_reset();
    for (int i = 0; i < NS; i++) pops[i] = 0;
    for (int p = 0; p < 5; p++) begin
      s = p % NS;
      rdat = '0;
      for (int i = 0; i < NS; i++) rdat |= mk(i, 16'hC000 | 16'(i << 8) | 16'(pops[i]));
      tick(4'b1111, rdat, 1'b1, rdy);
      chk("fair_hdr_ready", 64'(rdy), 64'h0);
      chk("fair_hdr", 64'(data_o), 64'(16'hA500 | 16'(s)));
      for (int k = 0; k < PW; k++) begin
        rdat = '0;
        for (int i = 0; i < NS; i++) rdat |= mk(i, 16'hC000 | 16'(i << 8) | 16'(pops[i]));
        tick(4'b1111, rdat, 1'b1, rdy);
        chk("fair_ready", 64'(rdy), 64'(1 << s));
        chk("fair_word", 64'(data_o), 64'(16'hC000 | 16'(s << 8) | 16'(pops[s])));
        pops[s]++;
      end
    end

    // Hold: no read strobe for 50 cycles in the middle of a packet.
    apply_reset();
    tick(4'b1000, mk(3, 16'h3330), 1'b1, rdy);
    chk("hold_hdr", 64'(data_o), 64'hA503);
    tick(4'b1000, mk(3, 16'h3330), 1'b1, rdy);
    tick(4'b1000, mk(3, 16'h3331), 1'b1, rdy);
    chk("hold_pre", 64'(data_o), 64'h3331);
    for (int i = 0; i < 50; i++) begin
      tick(4'($urandom_range(0, 15)), {$urandom, $urandom}, 1'b0, rdy);
      chk("hold_ready", 64'(rdy), 64'h0);
      chk("hold_data",  64'(data_o), 64'h3331);
      chk("hold_cnt",   64'(dbg_cnt), 64'd1);
      chk("hold_state", 64'(dbg_state), 64'(S_PLD));
    end
    tick(4'b1000, mk(3, 16'h3332), 1'b1, rdy);
    chk("hold_resume_ready", 64'(rdy), 64'b1000);
    chk("hold_resume", 64'(data_o), 64'h3332);
    tick(4'b1000, mk(3, 16'h3333), 1'b1, rdy);
    chk("hold_last", 64'(data_o), 64'h3333);
    tick(4'b0000, 64'h0, 1'b1, rdy);
    chk("hold_end_busy", 64'(busy_o), 64'h0);

    // Reset in the middle of a payload: asynchronous clear, source 0 next.
    apply_reset();
    tick(4'b0100, mk(2, 16'h2220), 1'b1, rdy);
    tick(4'b0100, mk(2, 16'h2220), 1'b1, rdy);
    tick(4'b0100, mk(2, 16'h2221), 1'b1, rdy);
    tick(4'b0100, mk(2, 16'h2222), 1'b1, rdy);
    chk("mrst_pre_cnt",  64'(dbg_cnt), 64'd2);
    chk("mrst_pre_data", 64'(data_o), 64'h2222);
    #2;
    src_valid   = 4'b1111;
    src_data    = mk(2, 16'h2223);
    data_read_i = 1'b1;
    reset       = 1'b0;
    #1;
    chk("mrst_data",  64'(data_o), 64'h0);
    chk("mrst_busy",  64'(busy_o), 64'h0);
    chk("mrst_ready", 64'(src_ready), 64'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_next_hdr", 64'(data_o), 64'hA500);

    // Randomized traffic against the packet-level model.
    apply_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < NS; b++) rv[b] = ($urandom_range(0, 9) < 7);
      rdat = {$urandom, $urandom};
      rrd  = ($urandom_range(0, 9) < 7);
      model_step(rv, rdat, rrd, e_rdy);
      tick(rv, rdat, rrd, rdy);
      chk("rnd_ready",    64'(rdy),        64'(e_rdy));
      chk("rnd_data",     64'(data_o),     64'(m_data));
      chk("rnd_busy",     64'(busy_o),     64'(m_src >= 0));
      chk("rnd_underrun", 64'(underrun_o), 64'(m_under));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lvds_tx_scheduler.md
LVDS_TX_SCHEDULER -- requirements
Module: lvds_tx_scheduler

Interface
REQ-001 Parameter NUM_BYTES, default 2, serializer word width in bytes (word = 8*NUM_BYTES bits, NUM_BYTES >= 2).
REQ-002 Parameter NUM_SRC, default 4, number of requesters (2..8).
REQ-003 Parameter PKT_WORDS, default 4, payload words per packet (1..255).
REQ-004 Parameter IDLE_WORD, default all-zero, word sent when idle or on underrun.
REQ-005 Parameter HDR_MARK, default 8'hA5, top byte of every header word.
REQ-006 clk  input  1  single clock; all logic on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 src_valid  input  NUM_SRC  per-source "payload word available".
REQ-009 src_data  input  NUM_SRC*8*NUM_BYTES  per-source payload word; source i occupies bits [i*W +: W].
REQ-010 src_ready  output  NUM_SRC  per-source one-cycle pop strobe.
REQ-011 data_o  output  8*NUM_BYTES  registered word presented to the 8b10b serializer.
REQ-012 data_read_i  input  1  serializer strobe: data_o is consumed in the cycle this is high.
REQ-013 busy_o  output  1  high while a packet (header or payload) is in data_o.
REQ-014 underrun_o  output  1  sticky flag: a granted source was not valid when its payload word was needed.

Function
REQ-015 The FSM SHALL track what data_o holds: S_IDLE (IDLE_WORD), S_HDR (header), S_PLD (payload word, index cnt).
REQ-016 data_o and the FSM SHALL change only on a rising edge where data_read_i=1; otherwise they hold.
REQ-017 In S_IDLE, or in S_PLD with cnt=PKT_WORDS-1, on data_read_i the block SHALL arbitrate round-robin over src_valid, starting at (last grant + 1) mod NUM_SRC.
REQ-018 If a winner g exists: load header {HDR_MARK, zeros, g in low byte}, latch grant=g, go to S_HDR; else load IDLE_WORD, go to S_IDLE.
REQ-019 In S_HDR on data_read_i: load src_data[g], cnt=0, go to S_PLD.
REQ-020 In S_PLD with cnt<PKT_WORDS-1 on data_read_i: load the next src_data[g] word, cnt+1.
REQ-021 src_ready[g] SHALL be high (combinationally) exactly in the cycle a payload word from g is loaded; all other bits 0.
REQ-022 If src_valid[g]=0 when a payload word is due: load IDLE_WORD, keep cnt and state, no src_ready, set underrun_o.
REQ-023 A packet, once granted, SHALL never be pre-empted; packet length on the wire is always 1+PKT_WORDS non-fill words.
REQ-024 Requests arriving in the same cycle as data_read_i SHALL be eligible for that arbitration.
REQ-025 busy_o = (state != S_IDLE).
REQ-026 Arithmetic: cnt is 8 bits, grant is clog2(NUM_SRC) bits, round-robin pointer wraps modulo NUM_SRC.

Reset
REQ-027 On reset=0, asynchronously: data_o=IDLE_WORD, state=S_IDLE, cnt=0, last grant=NUM_SRC-1 (so source 0 wins first), underrun_o=0.
REQ-028 src_ready SHALL be 0 while reset=0.
REQ-029 A reset mid-packet SHALL abandon the packet; the serializer sees IDLE_WORD next.

Structure
REQ-030 A shared package SHALL hold the state encoding (S_IDLE/S_HDR/S_PLD), HDR_MARK default and the header-format helper.
REQ-031 The round-robin arbiter SHALL be one sub-module, rr_arbiter (req, last grant in; one-hot grant, valid out, purely combinational).
REQ-032 Total RTL 120-400 lines; no memories, no FIFOs inside the block.

Verification
REQ-033 Idle: no src_valid, data_read_i every 10 cycles -> data_o stays 16'h0000, src_ready never asserted, busy_o=0.
REQ-034 Single source: src_valid[2]=1, data 16'h1111,16'h2222,16'h3333,16'h4444 -> wire sequence 16'hA502, 1111, 2222, 3333, 4444, then 16'h0000; four src_ready[2] pulses.
REQ-035 Fairness: all four sources valid continuously -> headers A500, A501, A502, A503, A500 in order, each followed by 4 payload words.
REQ-036 Underrun: source 1 drops valid for 3 strobes after its 2nd payload word -> three 16'h0000 fill words inserted, then remaining 2 words, underrun_o=1 until reset.
REQ-037 Hold: data_read_i low for 50 cycles mid-packet -> data_o, cnt and src_ready unchanged throughout.
REQ-038 Reset mid-packet: reset=0 during S_PLD cnt=2 -> data_o=16'h0000 immediately (asynchronous), next grant goes to source 0.
